// File: rtl/aes_inv_sbox_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_inv_sbox_engine                                            |
// | Purpose  : Iterative AES inverse S-box over a 128-bit state, LANES bytes  |
// |            per cycle, valid/ready on request and response.                |
// | Options  : AES_SBOX_FWD_EN adds fwd_mode and a forward S-box per lane.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module aes_inv_sbox_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
`ifdef AES_SBOX_FWD_EN
    input  logic         fwd_mode,
`endif
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         busy
);

    localparam int PASSES = 16 / LANES;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [CNT_W-1:0] c_last_pass = CNT_W'(PASSES - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_lookup = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    // Entry 0 sits in the most significant byte, so entry b is at bit 8*(255-b).
    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] f_inv_sbox(input logic [7:0] b);
        return c_inv_sbox[{~b, 3'b000} +: 8];
    endfunction

`ifdef AES_SBOX_FWD_EN
    localparam logic [2047:0] c_fwd_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_fwd_sbox(input logic [7:0] b);
        return c_fwd_sbox[{~b, 3'b000} +: 8];
    endfunction
`endif

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("aes_inv_sbox_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [127:0]     r_work;
    logic [127:0]     w_work_next;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_busy;
    logic             w_req_ready_next;
    logic             w_rsp_valid_next;
    logic             w_busy_next;
    logic             w_load;
    logic             w_step;
    logic [6:0]       w_bit_base;
    logic [7:0]       w_lane_in  [LANES];
    logic [7:0]       w_lane_out [LANES];
`ifdef AES_SBOX_FWD_EN
    logic             r_fwd;
`endif

    // First bit of the byte group handled in the current pass.
    assign w_bit_base = 7'(r_cnt) * 7'(LANES * 8);

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_lane_in[l] = r_work[w_bit_base + 7'(l * 8) +: 8];
`ifdef AES_SBOX_FWD_EN
            assign w_lane_out[l] = r_fwd ? f_fwd_sbox(w_lane_in[l]) : f_inv_sbox(w_lane_in[l]);
`else
            assign w_lane_out[l] = f_inv_sbox(w_lane_in[l]);
`endif
        end

        // Each byte takes its lane result only during the pass that owns it.
        for (genvar b = 0; b < 16; b++) begin : g_byte
            assign w_work_next[b*8 +: 8] = (r_cnt == CNT_W'(b / LANES)) ? w_lane_out[b % LANES]
                                                                         : r_work[b*8 +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next     = r_state;
        w_req_ready_next = r_req_ready;
        w_rsp_valid_next = r_rsp_valid;
        w_busy_next      = r_busy;
        w_load           = 1'b0;
        w_step           = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_req_ready_next = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_load           = 1'b1;
                    w_req_ready_next = 1'b0;
                    w_busy_next      = 1'b1;
                    w_state_next     = c_st_lookup;
                end
            end
            c_st_lookup: begin
                w_step = 1'b1;
                if (r_cnt == c_last_pass) begin
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = c_st_done;
                end
            end
            c_st_done: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_busy_next      = 1'b0;
                    w_req_ready_next = 1'b1;
                    w_state_next     = c_st_idle;
                end
            end
            default: begin
                w_req_ready_next = 1'b0;
                w_rsp_valid_next = 1'b0;
                w_busy_next      = 1'b0;
                w_state_next     = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_work      <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef AES_SBOX_FWD_EN
            r_fwd       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= w_req_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_busy      <= w_busy_next;
            if (w_load) begin
                r_work <= req_data;
                r_cnt  <= '0;
`ifdef AES_SBOX_FWD_EN
                r_fwd  <= fwd_mode;
`endif
            end else if (w_step) begin
                r_work <= w_work_next;
                r_cnt  <= (r_cnt == c_last_pass) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_work;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/aes_inv_sbox_engine.md
Name: aes_inv_sbox_engine

Overview:
Serves the S-box lookup side of the InvSubBytes interface. It accepts a 128-bit state word as a request and returns the word with every byte passed through the AES inverse S-box. Substitution runs in place over 16/LANES passes using LANES parallel 256-entry ROM lookups, with a valid/ready handshake on both request and response. It sits between the InvSubBytes stage (which drives old_sbox out and takes new_sbox back) and the round datapath.

Parameters:
LANES, 4, bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error (generate check).

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request word present on req_data
req_ready  output  1  engine can accept a request
req_data  input  128  state to substitute (old_sbox); byte i = bits [8i+7:8i]
rsp_valid  output  1  substituted word present on rsp_data
rsp_ready  input  1  consumer accepts the response
rsp_data  output  128  substituted state (new_sbox)
busy  output  1  high in LOOKUP or DONE

Behaviour:
- Reset values while reset_n is low: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, pass counter=0.
- req_ready is a registered bit. It rises at the first clk edge after reset_n deasserts.
- States: IDLE, LOOKUP, DONE. P = 16/LANES.
- IDLE: req_ready=1. If req_valid && req_ready at an edge, load req_data into the working register, set cnt=0, clear req_ready, set busy, and go to LOOKUP.
- LOOKUP: on each edge, replace bytes cnt*LANES through cnt*LANES+LANES-1 with InvSbox(byte). Lower byte indices are processed first. cnt increments.
  - If cnt==P-1 at that edge, go to DONE and set rsp_valid.
  - rsp_valid therefore rises at the P-th edge after the accepting edge (LANES=4 gives 4 edges; LANES=16 gives 1 edge).
- DONE: rsp_valid=1 and rsp_data = working register, held stable until the handshake.
  - On rsp_valid && rsp_ready at an edge: clear rsp_valid and busy, set req_ready, go to IDLE. The next request can be accepted on the following edge.
  - There is no overlap: one request is in flight at a time.
- rsp_data keeps the last result after the handshake, until the next load. The working register doubles as rsp_data.
- req_valid outside IDLE is ignored; data is not captured and there is no error.
- rsp_ready while rsp_valid=0 is ignored.
- req_data is sampled only at the accepting edge. Later changes have no effect.
- Asserting reset_n low mid-LOOKUP or mid-DONE abandons the operation immediately: outputs take their reset values and no partial response is ever issued.
- The ROM is combinational (case or constant table); each lane has its own lookup instance.

Optional Feature:
Macro AES_SBOX_FWD_EN.
- Defined: adds input port fwd_mode (1 bit), sampled at the accepting edge and held for the whole operation. 1 selects the forward S-box, 0 the inverse. Both ROMs are instantiated per lane, with the selection muxed per lane.
- Undefined: no fwd_mode port; inverse S-box only; forward ROM not built.

Test Plan:
- LANES=4. Send req_data=128'h6363...63 with rsp_ready=1 -> rsp_valid rises exactly 4 edges after acceptance; rsp_data=128'h0; req_ready=1 one edge after the handshake.
- req_data=128'h0 -> rsp_data=128'h5252...52. Repeat with LANES=1 (16 edges) and LANES=16 (1 edge); the result must be identical.
- Byte order: byte0=8'hED, byte15=8'h16, all other bytes 8'h63 -> rsp byte0=8'h53, byte15=8'hFF, all other bytes 8'h00.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises, and pulse req_valid with different data -> rsp_valid stays 1, rsp_data unchanged, req_ready=0, second request not captured.
- Drop reset_n low for 1 cycle after 2 LOOKUP passes -> rsp_valid=0, busy=0, rsp_data=0 immediately. After release, a new request for 128'h6363...63 returns 128'h0 normally.
- AES_SBOX_FWD_EN defined: fwd_mode=1 with 128'h0 -> 128'h6363...63; fwd_mode=1 with all bytes 8'h53 -> all bytes 8'hED; fwd_mode=0 behaves as the inverse S-box.
